// File: rtl/pic_pkg.sv
// Shared definitions for the programmable interrupt controller: register map,
// spurious vector offset and a lowest-set-bit helper used by the encoders.
package pic_pkg;

  localparam int unsigned PIC_MAX_IRQ = 16;
  localparam int unsigned PIC_IDX_MAX_W = 5;

  localparam logic [1:0] PIC_PENDING = 2'd0;
  localparam logic [1:0] PIC_MASK    = 2'd1;
  localparam logic [1:0] PIC_MODE    = 2'd2;
  localparam logic [1:0] PIC_ISR     = 2'd3;

  // Spurious vector sits this far past the last real line (VECTOR_BASE+NUM_IRQ).
  localparam int unsigned PIC_SPURIOUS = 0;

  function automatic logic [PIC_IDX_MAX_W-1:0] pic_lowest_set(
    input logic [PIC_MAX_IRQ-1:0] vec
  );
    logic [PIC_IDX_MAX_W-1:0] idx;
    idx = PIC_IDX_MAX_W'(PIC_MAX_IRQ);
    for (int i = PIC_MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = PIC_IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Priority encoder: index of the lowest set request bit (bit 0 wins),
// or W when nothing is requesting.
module pic_prio_enc
  import pic_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [PIC_MAX_IRQ-1:0]   req_pad;
  logic [PIC_IDX_MAX_W-1:0] low_idx;

  assign req_pad = PIC_MAX_IRQ'(req_i);
  assign low_idx = pic_lowest_set(req_pad);
  assign valid_o = |req_i;
  assign idx_o   = valid_o ? IDX_W'(low_idx) : IDX_W'(W);

endmodule

// File: rtl/pic_controller.sv
// Programmable interrupt controller: per-line mask and edge/level mode,
// pending/in-service tracking, nested priority, EOI and vectored acknowledge.
module pic_controller
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned VECTOR_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic              sel,
  input  logic [1:0]        addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              intack,
  output logic [DATA_W-1:0] vector,
  output logic              INT
);

  localparam int unsigned IDX_W = $clog2(NUM_IRQ + 1);

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic               int_q, int_d;

  logic [NUM_IRQ-1:0] wdata_n;
  logic               unused_wdata;
  logic               wr_pend, wr_mask, wr_mode, wr_isr;
  logic [NUM_IRQ-1:0] rise, pending, elig;
  logic [NUM_IRQ-1:0] hp_oh, hs_oh;
  logic [NUM_IRQ-1:0] ack_set, eoi_clr, w1c, mode_chg;
  logic [IDX_W-1:0]   hp_idx, hs_idx, vec_idx;
  logic               hp_valid, hs_valid;
  logic               int_raw, ack_ok;

  assign wdata_n      = wdata[NUM_IRQ-1:0];
  assign unused_wdata = ^wdata;

  // pend_q only ever holds edge-line latches; level lines follow irq_q directly.
  assign rise    = irq & ~irq_q & mode_q;
  assign pending = (pend_q & mode_q) | (irq_q & ~mode_q);
  assign elig    = pending & ~mask_q;

  pic_prio_enc #(
    .W     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_hp_enc (
    .req_i   (elig),
    .idx_o   (hp_idx),
    .valid_o (hp_valid)
  );

  pic_prio_enc #(
    .W     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_hs_enc (
    .req_i   (isr_q),
    .idx_o   (hs_idx),
    .valid_o (hs_valid)
  );

  assign int_raw = hp_valid & (hp_idx < hs_idx);
  assign ack_ok  = intack & int_raw;

  always_comb begin
    hp_oh = '0;
    hs_oh = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      hp_oh[i] = (hp_idx == IDX_W'(i));
      hs_oh[i] = (hs_idx == IDX_W'(i));
    end
  end

  // Register write decode and next-state; intack sees the pre-write state.
  always_comb begin
    wr_pend  = sel & wr & (addr == PIC_PENDING);
    wr_mask  = sel & wr & (addr == PIC_MASK);
    wr_mode  = sel & wr & (addr == PIC_MODE);
    wr_isr   = sel & wr & (addr == PIC_ISR);

    ack_set  = ack_ok ? hp_oh : '0;
    eoi_clr  = (wr_isr & hs_valid) ? hs_oh : '0;
    w1c      = wr_pend ? wdata_n : '0;
    mode_chg = wr_mode ? (wdata_n ^ mode_q) : '0;

    irq_d    = irq;
    pend_d   = (rise | (pend_q & ~w1c & ~ack_set)) & ~mode_chg;
    mask_d   = wr_mask ? wdata_n : mask_q;
    mode_d   = wr_mode ? wdata_n : mode_q;
    isr_d    = (isr_q & ~eoi_clr) | ack_set;
    int_d    = int_raw & ~ack_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q  <= '0;
      pend_q <= '0;
      mask_q <= '1;
      mode_q <= '0;
      isr_q  <= '0;
      int_q  <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      isr_q  <= isr_d;
      int_q  <= int_d;
    end
  end

  assign INT = int_q;

  assign vec_idx = int_raw ? hp_idx : IDX_W'(NUM_IRQ + PIC_SPURIOUS);

  always_comb begin
    vector = DATA_W'(VECTOR_BASE);
    if (!reset) vector = DATA_W'(VECTOR_BASE) + DATA_W'(vec_idx);
  end

  always_comb begin
    rdata = '0;
    case (addr)
      PIC_PENDING: rdata = DATA_W'(pending);
      PIC_MASK:    rdata = DATA_W'(mask_q);
      PIC_MODE:    rdata = DATA_W'(mode_q);
      default:     rdata = DATA_W'(isr_q);
    endcase
  end

endmodule

// File: tb/tb_pic_controller.sv
// Directed bench for pic_controller: expected vectors go through a scoreboard
// queue at acknowledge time; register and INT values are checked inline.
module tb_pic_controller;
  import pic_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  irq;
  logic        sel;
  logic [1:0]  addr;
  logic        wr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        intack;
  logic [15:0] vector;
  logic        int_w;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  pic_controller #(
    .NUM_IRQ     (8),
    .DATA_W      (16),
    .VECTOR_BASE (0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .irq    (irq),
    .sel    (sel),
    .addr   (addr),
    .wr     (wr),
    .wdata  (wdata),
    .rdata  (rdata),
    .intack (intack),
    .vector (vector),
    .INT    (int_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    sel   = 1'b1;
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    step();
    sel   = 1'b0;
    wr    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    check(tag, 32'(rdata), 32'(exp));
  endtask

  task automatic ack(input string tag, input logic [15:0] exp);
    logic [15:0] e;
    intack = 1'b1;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check(tag, 32'(vector), 32'(e));
    step();
    intack = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    irq    = '0;
    sel    = 1'b0;
    addr   = '0;
    wr     = 1'b0;
    wdata  = '0;
    intack = 1'b0;
    step();
    step();
    #1;
    check("rst_int", 32'(int_w), 32'd0);
    check("rst_vector", 32'(vector), 32'h0);
    rd_check("rst_mask", PIC_MASK, 16'h00FF);
    rd_check("rst_pend", PIC_PENDING, 16'h0000);
    rd_check("rst_mode", PIC_MODE, 16'h0000);
    rd_check("rst_isr", PIC_ISR, 16'h0000);
    reset = 1'b0;
    step();

    // Edge line 2
    reg_write(PIC_MASK, 16'h00FB);
    reg_write(PIC_MODE, 16'h0004);
    irq = 8'h04;
    step();
    irq = 8'h00;
    check("t1_int_early", 32'(int_w), 32'd0);
    step();
    check("t1_int", 32'(int_w), 32'd1);
    rd_check("t1_pend", PIC_PENDING, 16'h0004);
    ack("t1_vec", 16'h0002);
    check("t1_int_ack", 32'(int_w), 32'd0);
    rd_check("t1_isr", PIC_ISR, 16'h0004);
    rd_check("t1_pend_clr", PIC_PENDING, 16'h0000);
    reg_write(PIC_ISR, 16'h0000);
    rd_check("t1_isr_eoi", PIC_ISR, 16'h0000);

    // Level line 5
    reg_write(PIC_MASK, 16'h0000);
    reg_write(PIC_MODE, 16'h0000);
    irq = 8'h20;
    step();
    step();
    check("t2_int", 32'(int_w), 32'd1);
    ack("t2_vec", 16'h0005);
    check("t2_int_ack", 32'(int_w), 32'd0);
    step();
    check("t2_int_insvc", 32'(int_w), 32'd0);
    reg_write(PIC_ISR, 16'h0000);
    step();
    check("t2_int_again", 32'(int_w), 32'd1);
    ack("t2_vec2", 16'h0005);
    irq = 8'h00;
    step();
    step();
    reg_write(PIC_ISR, 16'h0000);
    step();
    check("t2_int_idle", 32'(int_w), 32'd0);
    rd_check("t2_isr", PIC_ISR, 16'h0000);

    // Nesting 3 -> 1, line 6 blocked until both EOIs
    irq = 8'h08;
    step();
    step();
    ack("t3_vec3", 16'h0003);
    irq = 8'h02;
    step();
    step();
    check("t3_int_nest", 32'(int_w), 32'd1);
    ack("t3_vec1", 16'h0001);
    rd_check("t3_isr_nest", PIC_ISR, 16'h000A);
    irq = 8'h40;
    step();
    step();
    check("t3_int_blocked", 32'(int_w), 32'd0);
    reg_write(PIC_ISR, 16'h0000);
    rd_check("t3_isr_eoi1", PIC_ISR, 16'h0008);
    step();
    check("t3_int_still", 32'(int_w), 32'd0);
    reg_write(PIC_ISR, 16'h0000);
    step();
    check("t3_int_l6", 32'(int_w), 32'd1);
    ack("t3_vec6", 16'h0006);
    irq = 8'h00;
    step();
    reg_write(PIC_ISR, 16'h0000);
    rd_check("t3_isr_end", PIC_ISR, 16'h0000);

    // Simultaneous edges on 4 and 7
    reg_write(PIC_MODE, 16'h0090);
    irq = 8'h90;
    step();
    irq = 8'h00;
    step();
    check("t4_int", 32'(int_w), 32'd1);
    ack("t4_vec_first", 16'h0004);
    rd_check("t4_isr", PIC_ISR, 16'h0010);
    rd_check("t4_pend", PIC_PENDING, 16'h0080);
    reg_write(PIC_ISR, 16'h0000);
    step();
    check("t4_int2", 32'(int_w), 32'd1);
    ack("t4_vec_second", 16'h0007);
    reg_write(PIC_ISR, 16'h0000);

    // Spurious acknowledge and W1C race
    reg_write(PIC_MASK, 16'h00FF);
    irq = 8'h10;
    step();
    irq = 8'h00;
    step();
    step();
    check("t5_int_masked", 32'(int_w), 32'd0);
    ack("t5_spur", 16'h0008);
    rd_check("t5_pend", PIC_PENDING, 16'h0010);
    rd_check("t5_isr", PIC_ISR, 16'h0000);
    reg_write(PIC_MODE, 16'h0091);
    irq   = 8'h01;
    sel   = 1'b1;
    wr    = 1'b1;
    addr  = PIC_PENDING;
    wdata = 16'h0001;
    step();
    sel   = 1'b0;
    wr    = 1'b0;
    wdata = '0;
    rd_check("t5_w1c_race", PIC_PENDING, 16'h0011);
    reg_write(PIC_PENDING, 16'h0010);
    rd_check("t5_w1c", PIC_PENDING, 16'h0001);
    irq = 8'h00;

    // Reset while a line is in service and another is pending
    reg_write(PIC_MODE, 16'h0012);
    reg_write(PIC_MASK, 16'h00FD);
    irq = 8'h02;
    step();
    irq = 8'h00;
    step();
    check("t6_int", 32'(int_w), 32'd1);
    ack("t6_vec", 16'h0001);
    irq = 8'h10;
    step();
    irq = 8'h00;
    step();
    rd_check("t6_isr", PIC_ISR, 16'h0002);
    rd_check("t6_pend", PIC_PENDING, 16'h0010);
    reset = 1'b1;
    #1;
    check("t6_rst_vector", 32'(vector), 32'h0);
    step();
    rd_check("t6_rst_pend", PIC_PENDING, 16'h0000);
    rd_check("t6_rst_isr", PIC_ISR, 16'h0000);
    rd_check("t6_rst_mask", PIC_MASK, 16'h00FF);
    check("t6_rst_int", 32'(int_w), 32'd0);
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
